// File: rtl/saph_float_stepper_pkg.sv
// Shared types for the float stepper: lane float type, step-mode and FSM state enums.
package saph_float_stepper_pkg;

    // IEEE-754 single precision, one per lane.
    typedef logic [31:0] float_t;

    typedef enum logic [1:0] {
        STEP_ADD = 2'd0,
        STEP_SUB = 2'd1,
        STEP_MUL = 2'd2
    } step_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Encoding 3 is reserved and behaves as ADD.
    function automatic step_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return STEP_SUB;
            2'd2:    return STEP_MUL;
            default: return STEP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/saph_float_stepper_if.sv
// FPU request/response bus between the stepper (master) and the FPU wrapper (slave).
interface saph_float_stepper_if #(
    parameter int unsigned LANES = 2
);
    import saph_float_stepper_pkg::*;

    logic               fpu_req_valid;
    logic               fpu_req_ready;
    logic [1:0]         fpu_req_op;
    float_t [LANES-1:0] fpu_req_a;
    float_t [LANES-1:0] fpu_req_b;
    logic               fpu_resp_valid;
    float_t [LANES-1:0] fpu_resp_res;

    modport master (
        output fpu_req_valid, fpu_req_op, fpu_req_a, fpu_req_b,
        input  fpu_req_ready, fpu_resp_valid, fpu_resp_res
    );

    modport slave (
        input  fpu_req_valid, fpu_req_op, fpu_req_a, fpu_req_b,
        output fpu_req_ready, fpu_resp_valid, fpu_resp_res
    );

endinterface

// File: rtl/saph_float_stepper.sv
// Repeatedly applies cur = cur (op) step through an external FPU, one request in flight,
// for a pending step total that callers can append to at any time.
module saph_float_stepper
    import saph_float_stepper_pkg::*;
#(
    parameter int unsigned LANES   = 2,
    parameter int unsigned COUNT_W = 4,
    parameter int unsigned REM_W   = COUNT_W + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 latch,
    input  logic [1:0]           mode,
    input  logic [COUNT_W-1:0]   count,
    input  float_t [LANES-1:0]   init,
    input  float_t [LANES-1:0]   step,
    output float_t [LANES-1:0]   cur,
    output logic                 ready,
    output logic                 done,
    saph_float_stepper_if.master fpu
);

    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    state_e             r_state;
    step_mode_e         r_mode;
    logic [REM_W-1:0]   r_rem;
    float_t [LANES-1:0] r_cur;
    logic               r_req_valid;
    logic               r_done;

    logic               w_retire;
    logic [REM_W-1:0]   w_rem_base;
    logic [REM_W:0]     w_rem_sum;
    logic [REM_W-1:0]   w_rem_next;

    // Latch clears first, a retiring step decrements, then the incoming count is added with saturation.
    always_comb begin
        w_retire = (r_state == ST_WAIT) && fpu.fpu_resp_valid && !latch;
        if (latch) begin
            w_rem_base = '0;
        end else if (w_retire && (r_rem != '0)) begin
            w_rem_base = r_rem - REM_ONE;
        end else begin
            w_rem_base = r_rem;
        end
        w_rem_sum  = {1'b0, w_rem_base} + {{(REM_W + 1 - COUNT_W){1'b0}}, count};
        w_rem_next = w_rem_sum[REM_W] ? '1 : w_rem_sum[REM_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= STEP_ADD;
            r_rem       <= '0;
            r_cur       <= '0;
            r_req_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rem  <= w_rem_next;
            r_done <= 1'b0;
            if (latch) begin
                r_cur  <= init;
                r_mode <= decode_mode(mode);
            end
            case (r_state)
                ST_IDLE: begin
                    if (!latch && (r_rem != '0)) begin
                        r_state     <= ST_ISSUE;
                        r_req_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (latch) begin
                        r_state     <= fpu.fpu_req_ready ? ST_DRAIN : ST_IDLE;
                        r_req_valid <= 1'b0;
                    end else if (fpu.fpu_req_ready) begin
                        r_state     <= ST_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A response coinciding with latch is dropped here, so nothing is left to drain.
                    if (latch) begin
                        r_state <= fpu.fpu_resp_valid ? ST_IDLE : ST_DRAIN;
                    end else if (fpu.fpu_resp_valid) begin
                        r_cur <= fpu.fpu_resp_res;
                        if (w_rem_next != '0) begin
                            r_state     <= ST_ISSUE;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fpu.fpu_resp_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cur   = r_cur;
    assign done  = r_done;
    assign ready = (r_state == ST_IDLE) && (r_rem == '0) && !latch;

    assign fpu.fpu_req_valid = r_req_valid;
    assign fpu.fpu_req_op    = r_mode;
    assign fpu.fpu_req_a     = r_cur;
    assign fpu.fpu_req_b     = step;

endmodule

// File: tb/tb_saph_float_stepper.sv
// Directed bench for saph_float_stepper with a fixed-latency behavioural FPU responder.
module tb_saph_float_stepper;
    import saph_float_stepper_pkg::*;

    localparam int unsigned LANES   = 2;
    localparam int unsigned COUNT_W = 4;
    localparam int unsigned LAT     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               latch;
    logic [1:0]         mode;
    logic [COUNT_W-1:0] count;
    float_t [LANES-1:0] init;
    float_t [LANES-1:0] step;
    float_t [LANES-1:0] cur;
    logic               ready;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_hs    = 0;

    saph_float_stepper_if #(.LANES(LANES)) fpu ();

    saph_float_stepper #(.LANES(LANES), .COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .latch (latch),
        .mode  (mode),
        .count (count),
        .init  (init),
        .step  (step),
        .cur   (cur),
        .ready (ready),
        .done  (done),
        .fpu   (fpu)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input float_t f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic float_t r2f(input real r);
        logic [63:0] d;
        logic [23:0] m;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        m = {1'b0, d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) m = m + 24'd1;
        if (m[23]) e = e + 1;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic real fop(input logic [1:0] op, input real a, input real b);
        case (op)
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a + b;
        endcase
    endfunction

    function automatic bit near(input float_t a, input real e);
        real d;
        d = f2r(a) - e;
        if (d < 0.0) d = -d;
        return d < 1.0e-4;
    endfunction

    // Responder: takes a request on valid&&ready, answers LAT cycles later, keeps going through rst.
    float_t [LANES-1:0] m_pend;
    int                 m_cnt  = 0;
    bit                 m_busy = 1'b0;
    initial begin : fpu_model
        fpu.fpu_resp_valid = 1'b0;
        fpu.fpu_resp_res   = '0;
        m_pend             = '0;
        forever begin
            @(negedge clk);
            #1;
            if (fpu.fpu_resp_valid) fpu.fpu_resp_valid = 1'b0;
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    fpu.fpu_resp_res   = m_pend;
                    fpu.fpu_resp_valid = 1'b1;
                    m_busy             = 1'b0;
                end
            end
            if (!m_busy && fpu.fpu_req_valid && fpu.fpu_req_ready) begin
                for (int i = 0; i < LANES; i++)
                    m_pend[i] = r2f(fop(fpu.fpu_req_op, f2r(fpu.fpu_req_a[i]), f2r(fpu.fpu_req_b[i])));
                m_busy = 1'b1;
                m_cnt  = LAT;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One cycle of stimulus; tallies done pulses and handshakes that happen at the next edge.
    task automatic tick(input logic l, input logic [COUNT_W-1:0] c, input logic r);
        @(negedge clk);
        if (done) n_done++;
        latch = l;
        count = c;
        fpu.fpu_req_ready = r;
        if (fpu.fpu_req_valid && r) n_hs++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; latch = 1'b0; mode = 2'd0; count = '0;
        init = '0; step = '0; fpu.fpu_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 1", ready); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (cur !== '0) begin n_fail++; $display("FAIL reset_cur: got %h want 0", cur); end
        n_tests++; if (fpu.fpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fpu.fpu_req_valid); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_add_basic;
        mode = 2'd0;
        init[0] = r2f(1.010); init[1] = r2f(3.141);
        step[0] = r2f(0.125); step[1] = r2f(0.001);
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd3, 1'b1);
        run(20);
        n_tests++; if (n_hs !== 3) begin n_fail++; $display("FAIL add_steps: got %0d want 3", n_hs); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL add_done: got %0d want 1", n_done); end
        n_tests++; if (!near(cur[0], 1.385)) begin n_fail++; $display("FAIL add_lane0: got %f want 1.385", f2r(cur[0])); end
        n_tests++; if (!near(cur[1], 3.144)) begin n_fail++; $display("FAIL add_lane1: got %f want 3.144", f2r(cur[1])); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", ready); end
    endtask

    task automatic test_append;
        n_done = 0; n_hs = 0;
        for (int i = 0; i < 35; i++)
            tick(i == 0, (i == 2) ? 4'd3 : (i == 6) ? 4'd1 : 4'd0, 1'b1);
        n_tests++; if (n_hs !== 4) begin n_fail++; $display("FAIL append_steps: got %0d want 4", n_hs); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL append_done: got %0d want 1", n_done); end
        n_tests++; if (!near(cur[0], 1.510)) begin n_fail++; $display("FAIL append_lane0: got %f want 1.510", f2r(cur[0])); end
        n_tests++; if (!near(cur[1], 3.145)) begin n_fail++; $display("FAIL append_lane1: got %f want 3.145", f2r(cur[1])); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL append_ready: got %b want 1", ready); end
    endtask

    task automatic test_mul_sub;
        mode = 2'd2;
        init[0] = 32'h3F80_0000; init[1] = 32'h3FC0_0000;   // 1.0, 1.5
        step[0] = 32'h4000_0000; step[1] = 32'h4000_0000;   // 2.0
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd5, 1'b1);
        run(25);
        n_tests++; if (cur[0] !== 32'h4200_0000) begin n_fail++; $display("FAIL mul_lane0: got %h want 42000000", cur[0]); end
        n_tests++; if (cur[1] !== 32'h4240_0000) begin n_fail++; $display("FAIL mul_lane1: got %h want 42400000", cur[1]); end
        n_tests++; if (n_hs !== 5) begin n_fail++; $display("FAIL mul_steps: got %0d want 5", n_hs); end
        mode = 2'd1;
        init[0] = 32'h3F80_0000; init[1] = 32'h4000_0000;   // 1.0, 2.0
        step[0] = 32'h3E80_0000; step[1] = 32'h3F00_0000;   // 0.25, 0.5
        n_done = 0;
        tick(1'b1, 4'd4, 1'b1);
        run(20);
        n_tests++; if (cur !== '0) begin n_fail++; $display("FAIL sub_zero: got %h want 0", cur); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL sub_done: got %0d want 1", n_done); end
    endtask

    task automatic test_reserved_mode;
        mode = 2'd3;
        init[0] = 32'h3F80_0000; init[1] = 32'h0000_0000;   // 1.0, 0.0
        step[0] = 32'h3F00_0000; step[1] = 32'h3E80_0000;   // 0.5, 0.25
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd2, 1'b1);
        tick(1'b0, 4'd0, 1'b1);
        tick(1'b0, 4'd0, 1'b1);
        n_tests++; if (fpu.fpu_req_valid !== 1'b1) begin n_fail++; $display("FAIL rsv_valid: got %b want 1", fpu.fpu_req_valid); end
        n_tests++; if (fpu.fpu_req_op !== 2'd0) begin n_fail++; $display("FAIL rsv_op: got %0d want 0", fpu.fpu_req_op); end
        n_tests++; if (fpu.fpu_req_a !== {32'h0000_0000, 32'h3F80_0000}) begin n_fail++; $display("FAIL rsv_a: got %h want 000000003f800000", fpu.fpu_req_a); end
        run(15);
        n_tests++; if (cur[0] !== 32'h4000_0000) begin n_fail++; $display("FAIL rsv_lane0: got %h want 40000000", cur[0]); end
        n_tests++; if (cur[1] !== 32'h3F00_0000) begin n_fail++; $display("FAIL rsv_lane1: got %h want 3f000000", cur[1]); end
    endtask

    task automatic test_stall;
        mode = 2'd0;
        init[0] = 32'h3F80_0000; init[1] = 32'h4000_0000;   // 1.0, 2.0
        step[0] = 32'h3F00_0000; step[1] = 32'h3F00_0000;   // 0.5
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd2, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 4'd0, 1'b0);
            n_tests++; if (fpu.fpu_req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, fpu.fpu_req_valid); end
            n_tests++; if (fpu.fpu_req_a !== {32'h4000_0000, 32'h3F80_0000}) begin n_fail++; $display("FAIL stall_a[%0d]: got %h want 400000003f800000", k, fpu.fpu_req_a); end
            n_tests++; if (fpu.fpu_req_b !== {32'h3F00_0000, 32'h3F00_0000}) begin n_fail++; $display("FAIL stall_b[%0d]: got %h want 3f0000003f000000", k, fpu.fpu_req_b); end
            n_tests++; if (fpu.fpu_req_op !== 2'd0) begin n_fail++; $display("FAIL stall_op[%0d]: got %0d want 0", k, fpu.fpu_req_op); end
        end
        run(20);
        n_tests++; if (n_hs !== 2) begin n_fail++; $display("FAIL stall_steps: got %0d want 2", n_hs); end
        n_tests++; if (cur[0] !== 32'h4000_0000) begin n_fail++; $display("FAIL stall_lane0: got %h want 40000000", cur[0]); end
        n_tests++; if (cur[1] !== 32'h4040_0000) begin n_fail++; $display("FAIL stall_lane1: got %h want 40400000", cur[1]); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", n_done); end
    endtask

    task automatic test_withdraw;
        mode = 2'd0;
        init[0] = 32'h3F80_0000; init[1] = 32'h3F80_0000;
        step[0] = 32'h3F80_0000; step[1] = 32'h3F80_0000;
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd2, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        n_tests++; if (fpu.fpu_req_valid !== 1'b1) begin n_fail++; $display("FAIL wd_valid_before: got %b want 1", fpu.fpu_req_valid); end
        init[0] = 32'h40A0_0000; init[1] = 32'h40A0_0000;   // 5.0
        tick(1'b1, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 1'b1);
        n_tests++; if (fpu.fpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL wd_valid_after: got %b want 0", fpu.fpu_req_valid); end
        run(10);
        n_tests++; if (cur !== {32'h40A0_0000, 32'h40A0_0000}) begin n_fail++; $display("FAIL wd_cur: got %h want 40a0000040a00000", cur); end
        n_tests++; if (n_hs !== 0) begin n_fail++; $display("FAIL wd_steps: got %0d want 0", n_hs); end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL wd_done: got %0d want 0", n_done); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL wd_ready: got %b want 1", ready); end
    endtask

    task automatic test_drain;
        mode = 2'd0;
        init[0] = 32'h3F80_0000; init[1] = 32'h3F80_0000;
        step[0] = 32'h3F80_0000; step[1] = 32'h3F80_0000;
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd4, 1'b1);
        for (int k = 0; k < 10 && n_hs == 0; k++) tick(1'b0, 4'd0, 1'b1);
        n_tests++; if (n_hs !== 1) begin n_fail++; $display("FAIL drain_issue: got %0d want 1", n_hs); end
        init[0] = 32'h40E0_0000; init[1] = 32'h40E0_0000;   // 7.0
        tick(1'b1, 4'd0, 1'b1);
        n_done = 0; n_hs = 0;
        run(10);
        n_tests++; if (cur !== {32'h40E0_0000, 32'h40E0_0000}) begin n_fail++; $display("FAIL drain_cur: got %h want 40e0000040e00000", cur); end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL drain_done: got %0d want 0", n_done); end
        n_tests++; if (n_hs !== 0) begin n_fail++; $display("FAIL drain_steps: got %0d want 0", n_hs); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b want 1", ready); end
    endtask

    task automatic test_saturate;
        mode = 2'd0;
        init = '0;
        step[0] = 32'h3F80_0000; step[1] = 32'h3F00_0000;   // 1.0, 0.5
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd15, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 4'd15, 1'b0);
        run(210);
        n_tests++; if (n_hs !== 63) begin n_fail++; $display("FAIL sat_steps: got %0d want 63", n_hs); end
        n_tests++; if (cur[0] !== 32'h427C_0000) begin n_fail++; $display("FAIL sat_lane0: got %h want 427c0000", cur[0]); end
        n_tests++; if (cur[1] !== 32'h41FC_0000) begin n_fail++; $display("FAIL sat_lane1: got %h want 41fc0000", cur[1]); end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL sat_done: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_mid_wait;
        mode = 2'd0;
        init[0] = 32'h3F80_0000; init[1] = 32'h3F80_0000;
        step[0] = 32'h3F80_0000; step[1] = 32'h3F80_0000;
        n_done = 0; n_hs = 0;
        tick(1'b1, 4'd3, 1'b1);
        for (int k = 0; k < 10 && n_hs == 0; k++) tick(1'b0, 4'd0, 1'b1);
        n_tests++; if (n_hs !== 1) begin n_fail++; $display("FAIL rstw_issue: got %0d want 1", n_hs); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (cur !== '0) begin n_fail++; $display("FAIL rstw_cur: got %h want 0", cur); end
        n_tests++; if (fpu.fpu_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid: got %b want 0", fpu.fpu_req_valid); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstw_ready: got %b want 1", ready); end
        @(negedge clk);
        rst = 1'b0;
        n_done = 0; n_hs = 0;
        run(10);
        n_tests++; if (cur !== '0) begin n_fail++; $display("FAIL rstw_cur_after: got %h want 0", cur); end
        n_tests++; if (n_hs !== 0) begin n_fail++; $display("FAIL rstw_steps: got %0d want 0", n_hs); end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL rstw_done: got %0d want 0", n_done); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstw_ready_after: got %b want 1", ready); end
    endtask

    initial begin
        test_reset;
        test_add_basic;
        test_append;
        test_mul_sub;
        test_reserved_mode;
        test_stall;
        test_withdraw;
        test_drain;
        test_saturate;
        test_reset_mid_wait;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/saph_float_stepper.md
SAPH_FLOAT_STEPPER -- requirements
Module: saph_float_stepper

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning the number of independent float lanes.
REQ-002 SHALL have parameter COUNT_W, default 4, meaning the width of the count input.
REQ-003 SHALL have parameter REM_W, default COUNT_W+2, meaning the width of the internal remaining-steps counter.
REQ-004 SHALL have port clk, input, 1 bit: GPU clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port latch, input, 1 bit: load init into cur and sample mode.
REQ-007 SHALL have port mode, input, 2 bits: ADD=0, SUB=1, MUL=2; 3 is reserved and treated as ADD.
REQ-008 SHALL have port count, input, COUNT_W bits: steps to append to the pending total.
REQ-009 SHALL have port init, input, float[LANES]: start values.
REQ-010 SHALL have port step, input, float[LANES]: per-lane operand.
REQ-011 SHALL have port cur, output, float[LANES]: current values.
REQ-012 SHALL have port ready, output, 1 bit: idle with zero steps pending.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the last pending step retires.
REQ-014 SHALL have FPU request and response ports:
- fpu_req_valid (out, 1), fpu_req_ready (in, 1), fpu_req_op (out, 2: ADD/SUB/MUL), fpu_req_a (out, float[LANES]), fpu_req_b (out, float[LANES]).
- fpu_resp_valid (in, 1), fpu_resp_res (in, float[LANES]).

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE and WAIT, with at most one FPU request outstanding.
REQ-016 SHALL, when latch=1, load cur<=init, latch the mode register, clear rem and go to IDLE (or DRAIN if a request is outstanding), all in the same cycle.
REQ-017 SHALL add count to rem every cycle, saturating at 2^REM_W-1. When latch and count coincide, the clear from latch applies first and count is then added.
REQ-018 SHALL leave IDLE for ISSUE in the cycle after rem becomes nonzero.
REQ-019 SHALL, in ISSUE, drive fpu_req_valid=1, fpu_req_a=cur, fpu_req_b=step and fpu_req_op=mode, holding all of them stable until fpu_req_ready. On the handshake it SHALL go to WAIT.
REQ-020 SHALL, in WAIT on fpu_resp_valid, set cur<=fpu_resp_res and rem<=rem-1 (plus any count arriving that cycle). If the result is nonzero it SHALL go to ISSUE; otherwise it SHALL go to IDLE and pulse done in the following cycle.
REQ-021 SHALL add a DRAIN state entered when latch occurs in WAIT, or in ISSUE after the handshake. In DRAIN the next fpu_resp_valid SHALL be discarded (cur is not updated) and the FSM SHALL then go to IDLE.
REQ-022 SHALL permit latch in ISSUE before the handshake, which withdraws the request (valid drops the next cycle) and goes to IDLE.
REQ-023 SHALL drive ready=1 only when state==IDLE, rem==0 and latch==0.
REQ-024 SHALL ignore fpu_resp_valid in IDLE and ISSUE.
REQ-025 SHALL read step live at issue time; step is not latched.
REQ-026 SHALL have a best-case steady-state throughput of one step per 2 + FPU-latency cycles.

Reset
REQ-027 SHALL, on rst, asynchronously force state=IDLE, rem=0, mode register=ADD, cur=all-zero (+0.0), fpu_req_valid=0 and done=0. ready SHALL then read 1.
REQ-028 SHALL treat a response arriving in the first cycle after reset deassertion as discarded.

Structure
REQ-029 SHALL place the step-mode enum (ADD/SUB/MUL) and the FSM state enum in the shared saph package; float continues to come from saph_defines.svh.
REQ-030 SHALL be a single module with no sub-modules. The FPU connection is made at the top level via the existing FPU wrapper.

Verification
REQ-031 SHALL cover: latch with LANES=2, init={1.010, 3.141}, step={0.125, 0.001}, ADD, count=3 -> cur={1.385, 3.144}, one done pulse, then ready=1.
REQ-032 SHALL cover: count=3 at cycle 2 and count=1 at cycle 6 while busy -> exactly 4 steps, cur={1.510, 3.145}, a single done pulse.
REQ-033 SHALL cover: MUL, init=1.0, step=2.0, count=5 -> cur=32.0; SUB, init=1.0, step=0.25, count=4 -> cur=0.0.
REQ-034 SHALL cover: latch during WAIT with init=7.0 -> the late response is discarded, cur=7.0, ready=1, no done pulse.
REQ-035 SHALL cover: fpu_req_ready held low for 10 cycles -> req fields stable and valid held, no step lost.
REQ-036 SHALL cover: rst asserted mid-WAIT -> cur=+0.0, valid=0 and ready=1 immediately; the following response is ignored.
